// File: rtl/mem_fill_pkg.sv
// Shared types for the memory initialiser: fill-mode and FSM state encodings.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_fill_pkg;

    typedef enum logic [1:0] {
        IDENTITY = 2'd0,
        CONST    = 2'd1,
        STRIDE   = 2'd2,
        RSVD     = 2'd3
    } fill_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2
    } state_t;

endpackage

// File: rtl/mem_fill_if.sv
// Start handshake plus single-port RAM bus between the initialiser and its environment.
// Latency: n/a (wiring only).
// Backpressure: en is honoured only while rdy is high; the RAM side has no stall.
interface mem_fill_if #(
    parameter int AW = 8,
    parameter int DW = 8
) ();
    logic          en;
    logic          rdy;
    logic [1:0]    mode;
    logic [DW-1:0] seed;
    logic [DW-1:0] stride;
    logic [AW-1:0] addr;
    logic [DW-1:0] wrdata;
    logic          wren;
    logic [DW-1:0] rddata;
    logic          err;
    logic [AW-1:0] err_addr;

    // Initialiser side: drives the RAM port and the status outputs.
    modport master (
        input  en, mode, seed, stride, rddata,
        output rdy, addr, wrdata, wren, err, err_addr
    );

    // Environment side: requests fills and returns RAM read data.
    modport slave (
        output en, mode, seed, stride, rddata,
        input  rdy, addr, wrdata, wren, err, err_addr
    );
endinterface

// File: rtl/mem_fill_gen.sv
// Pattern generator: index counter plus stride accumulator, word output registered.
// Latency: word/idx for index 0 valid the cycle after load/restart, then one step per cycle.
// Backpressure: none; advances only when step is asserted by the controller.
module mem_fill_gen
    import mem_fill_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          restart,
    input  logic          step,
    input  fill_mode_t    mode,
    input  logic [DW-1:0] seed,
    input  logic [DW-1:0] stride,
    output logic [AW:0]   idx,
    output logic [DW-1:0] word
);

    fill_mode_t    mode_q;
    logic [DW-1:0] seed_q;
    logic [DW-1:0] stride_q;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] word_q;
    logic [AW:0]   idx_q;

    logic [AW:0]   idx_nxt;
    logic [DW-1:0] acc_nxt;

    // The accumulator always holds seed + idx*stride, so stride mode needs no multiplier.
    function automatic logic [DW-1:0] pattern(input fill_mode_t m, input logic [AW:0] i,
                                              input logic [DW-1:0] s, input logic [DW-1:0] a);
        case (m)
            CONST:   return s;
            STRIDE:  return a;
            default: return DW'(i);   // IDENTITY and the reserved code
        endcase
    endfunction

    assign idx_nxt = idx_q + 1'b1;
    assign acc_nxt = acc_q + stride_q;

    // Load latches the run parameters; restart rewinds for a second pass with the same parameters.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= IDENTITY;
            seed_q   <= '0;
            stride_q <= '0;
            acc_q    <= '0;
            word_q   <= '0;
            idx_q    <= '0;
        end else if (load) begin
            mode_q   <= mode;
            seed_q   <= seed;
            stride_q <= stride;
            idx_q    <= '0;
            acc_q    <= seed;
            word_q   <= pattern(mode, '0, seed, seed);
        end else if (restart) begin
            idx_q    <= '0;
            acc_q    <= seed_q;
            word_q   <= pattern(mode_q, '0, seed_q, seed_q);
        end else if (step) begin
            idx_q    <= idx_nxt;
            acc_q    <= acc_nxt;
            word_q   <= pattern(mode_q, idx_nxt, seed_q, acc_nxt);
        end
    end

    assign idx  = idx_q;
    assign word = word_q;

endmodule

// File: rtl/mem_fill.sv
// RAM initialiser: on accepted en, writes DEPTH pattern words; MEM_FILL_VERIFY_EN adds a read-back pass.
// Latency: writes in cycles 1..DEPTH after accept, rdy at DEPTH+1 (2*DEPTH+2 with verify).
// Backpressure: rdy low while busy; en is ignored until rdy returns, RAM port never stalls.
module mem_fill
    import mem_fill_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    mem_fill_if.master bus
);

    // Index stops at DEPTH-1 for writes so odd depths never reach address DEPTH.
    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
`ifdef MEM_FILL_VERIFY_EN
    // The verify pass runs one extra index to drain the final compare.
    localparam logic [AW:0] END_IDX  = (AW+1)'(DEPTH);
`endif

    state_t        state_q;
    state_t        state_d;
    logic          load;
    logic          restart;
    logic          step;
    logic          rdy_q;
    logic          wren_q;
    logic [AW-1:0] addr_q;
    logic [AW:0]   gen_idx;
    logic [DW-1:0] gen_word;

    mem_fill_gen #(.AW(AW), .DW(DW)) u_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .restart (restart),
        .step    (step),
        .mode    (fill_mode_t'(bus.mode)),
        .seed    (bus.seed),
        .stride  (bus.stride),
        .idx     (gen_idx),
        .word    (gen_word)
    );

    // Next-state and generator control.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        restart = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    load    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (gen_idx == LAST_IDX) begin
`ifdef MEM_FILL_VERIFY_EN
                    restart = 1'b1;
                    state_d = VERIFY;
`else
                    state_d = IDLE;
`endif
                end else begin
                    step = 1'b1;
                end
            end
`ifdef MEM_FILL_VERIFY_EN
            VERIFY: begin
                if (gen_idx == END_IDX) begin
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; rdy/wren follow the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            wren_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == IDLE);
            wren_q  <= (state_d == WRITE);
            if (load || restart) begin
                addr_q <= '0;
            end else if (step && (gen_idx != LAST_IDX)) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign bus.rdy    = rdy_q;
    assign bus.wren   = wren_q;
    assign bus.addr   = addr_q;
    assign bus.wrdata = gen_word;

`ifdef MEM_FILL_VERIFY_EN
    logic          cmp_vld_q;
    logic [DW-1:0] exp_q;
    logic [AW-1:0] cmp_addr_q;
    logic          err_q;
    logic [AW-1:0] err_addr_q;

    // Delay expected word and address to line up with the RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_vld_q  <= 1'b0;
            exp_q      <= '0;
            cmp_addr_q <= '0;
        end else begin
            cmp_vld_q  <= (state_q == VERIFY) && (gen_idx != END_IDX);
            exp_q      <= gen_word;
            cmp_addr_q <= addr_q;
        end
    end

    // Sticky error capturing only the first mismatching address of a run.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (load) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (cmp_vld_q && (bus.rddata != exp_q) && !err_q) begin
            err_q      <= 1'b1;
            err_addr_q <= cmp_addr_q;
        end
    end

    assign bus.err      = err_q;
    assign bus.err_addr = err_addr_q;
`else
    logic unused_rddata;

    assign unused_rddata = ^bus.rddata;
    assign bus.err       = 1'b0;
    assign bus.err_addr  = '0;
`endif

endmodule
